// File: rtl/weight_prefetch_v2.sv
// Weight prefetcher: streams a run of beats from DDR in bursts into a first-word-fall-through FIFO.
// Optional feature: define WEIGHT_PF_WRAP_EN to loop over the same region until flushed.
module weight_prefetch_v2 #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_SIZE  = 32,
  parameter int LEN_WIDTH  = 10,
  parameter int BURST_LEN  = 32,
  parameter int FIFO_DEPTH = 512,
  parameter int PEMPTY_TH  = 64,
  parameter int BEAT_CNT_W = 20
) (
  input  logic                  s_clk,
  input  logic                  s_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_SIZE-1:0]  i_base_addr,
  input  logic [BEAT_CNT_W-1:0] i_total_beats,
  input  logic                  i_flush,
  output logic                  rd_burst_req,
  output logic [ADDR_SIZE-1:0]  rd_burst_addr,
  output logic [LEN_WIDTH-1:0]  rd_burst_len,
  input  logic [DATA_WIDTH-1:0] rd_burst_data,
  input  logic                  rd_burst_valid,
  input  logic                  rd_burst_finish,
  output logic [DATA_WIDTH-1:0] o_weight_data,
  output logic                  o_weight_valid,
  input  logic                  i_weight_ready,
  output logic                  o_pempty,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int SUM_W      = CNT_W + 1;
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [BEAT_CNT_W-1:0] remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  fifo_clr;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;
  logic                  fifo_full, wr_req, wr_en, rd_en;

  logic [BEAT_CNT_W-1:0] rem_after;
  logic [LEN_WIDTH-1:0]  next_len;
  logic [ADDR_SIZE-1:0]  addr_step;
  logic                  space_ok;

`ifdef WEIGHT_PF_WRAP_EN
  logic [ADDR_SIZE-1:0]  base_q;
  logic [BEAT_CNT_W-1:0] total_q;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      base_q  <= '0;
      total_q <= '0;
    end else if (state_q == ST_IDLE && i_start && !i_flush) begin
      base_q  <= i_base_addr;
      total_q <= i_total_beats;
    end
  end
`endif

  // Issue a burst only when the whole of it is guaranteed to fit in the FIFO.
  assign space_ok  = (SUM_W'(count_q) + SUM_W'(BURST_LEN)) <= SUM_W'(FIFO_DEPTH);
  assign next_len  = (remaining_q < BEAT_CNT_W'(BURST_LEN)) ? LEN_WIDTH'(remaining_q)
                                                            : LEN_WIDTH'(BURST_LEN);
  assign rem_after = remaining_q - BEAT_CNT_W'(len_q);
  assign addr_step = addr_q + (ADDR_SIZE'(len_q) << BYTE_SHIFT);

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    req_d       = req_q;
    done_d      = 1'b0;
    fifo_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_flush) begin
          fifo_clr = 1'b1;
        end else if (i_start) begin
          if (i_total_beats == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = i_base_addr;
            remaining_d = i_total_beats;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (i_flush) begin
          fifo_clr = 1'b1;
          state_d  = ST_IDLE;
        end else if (remaining_q != '0 && space_ok) begin
          req_d   = 1'b1;
          len_d   = next_len;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_flush) begin
          // A burst that completes in the flush cycle leaves nothing more to discard.
          if (rd_burst_finish) begin
            fifo_clr = 1'b1;
            req_d    = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end else if (rd_burst_finish) begin
          req_d       = 1'b0;
          addr_d      = addr_step;
          remaining_d = rem_after;
          state_d     = ST_ISSUE;
          if (rem_after == '0) begin
            done_d = 1'b1;
`ifdef WEIGHT_PF_WRAP_EN
            addr_d      = base_q;
            remaining_d = total_q;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_FLUSH: begin
        if (rd_burst_finish) begin
          fifo_clr = 1'b1;
          req_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      req_q       <= req_d;
      done_q      <= done_d;
    end
  end

  // Beats still arriving for a flushed burst are dropped on the floor.
  assign fifo_full = count_q == CNT_W'(FIFO_DEPTH);
  assign wr_req    = rd_burst_valid && (state_q != ST_FLUSH);
  assign wr_en     = wr_req && !fifo_full;
  assign rd_en     = o_weight_valid && i_weight_ready;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (wr_req && fifo_full) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge s_clk) begin
    if (wr_en) mem[wr_ptr_q] <= rd_burst_data;
  end

  assign o_weight_data  = mem[rd_ptr_q];
  assign o_weight_valid = count_q != '0;
  assign o_pempty       = 32'(count_q) < PEMPTY_TH;
  assign o_busy         = state_q != ST_IDLE;
  assign o_done         = done_q;
  assign o_overflow     = overflow_q;
  assign rd_burst_req   = req_q;
  assign rd_burst_addr  = addr_q;
  assign rd_burst_len   = len_q;

endmodule

// File: tb/tb_weight_prefetch_v2.sv
// Self-checking bench for weight_prefetch_v2: DDR responder, occupancy/stream model, directed and random jobs.
`timescale 1ns/1ps
module tb_weight_prefetch_v2;
  localparam int DW = 64, AW = 32, LW = 10, BL = 32, DEPTH = 512, PTH = 64, BCW = 20;

  logic          s_clk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [BCW-1:0] i_total_beats = '0;
  logic          i_flush;
  logic          flush_main = 1'b0, flush_slave;
  logic          rd_burst_req;
  logic [AW-1:0] rd_burst_addr;
  logic [LW-1:0] rd_burst_len;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_valid, rd_burst_finish;
  logic          v_slave, v_main = 1'b0;
  logic [DW-1:0] d_slave, d_main = '0;
  logic [DW-1:0] o_weight_data;
  logic          o_weight_valid, i_weight_ready;
  logic          o_pempty, o_busy, o_done, o_overflow;

  assign i_flush        = flush_main | flush_slave;
  assign rd_burst_valid = v_slave | v_main;
  assign rd_burst_data  = v_main ? d_main : d_slave;

  weight_prefetch_v2 dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_total_beats(i_total_beats), .i_flush(i_flush), .rd_burst_req(rd_burst_req),
    .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len), .rd_burst_data(rd_burst_data),
    .rd_burst_valid(rd_burst_valid), .rd_burst_finish(rd_burst_finish),
    .o_weight_data(o_weight_data), .o_weight_valid(o_weight_valid), .i_weight_ready(i_weight_ready),
    .o_pempty(o_pempty), .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
  );

  always #5 s_clk = ~s_clk;

  int n_checks = 0, n_pass = 0;
  logic [AW-1:0] job_base = '0;
  int job_total = 0, obs_base = 0, ready_mode = 0, gap_max = 0, flush_at = 0;
  bit chk_en = 1'b0;
  int n_obs = 0;
  logic [AW-1:0] obs_addr [0:255];
  logic [LW-1:0] obs_len  [0:255];
  int mcount = 0, out_idx = 0, acc_cnt = 0, done_cnt = 0;
  int d0, a0, c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Each beat carries a signature of its own byte address, so order and placement are visible.
  function automatic logic [63:0] data_fn(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a + 32'h0001_2345};
  endfunction

  initial begin : ready_drv
    i_weight_ready = 1'b0;
    forever begin
      @(negedge s_clk);
      case (ready_mode)
        0:       i_weight_ready = 1'b0;
        1:       i_weight_ready = 1'b1;
        default: i_weight_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // DDR responder: checks each request against the expected burst plan, then returns the beats.
  initial begin : ddr_slave
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    int k, rem, gap;
    bit ab;
    v_slave = 1'b0; d_slave = '0; rd_burst_finish = 1'b0; flush_slave = 1'b0;
    forever begin
      @(negedge s_clk);
      if (s_rst_n && rd_burst_req) begin
        a = rd_burst_addr; l = rd_burst_len;
        k = n_obs - obs_base;
        rem = job_total - k * BL;
        if (n_obs < 256) begin obs_addr[n_obs] = a; obs_len[n_obs] = l; end
        n_obs++;
        check("burst_addr", a, job_base + 32'(k * BL * (DW / 8)));
        check("burst_len", l, (rem < BL) ? rem : BL);
        ab = 1'b0;
        for (int j = 0; j < int'(l) && !ab; j++) begin
          gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
          repeat (gap) begin
            @(negedge s_clk);
            if (!s_rst_n) ab = 1'b1;
          end
          if (!ab) begin
            v_slave = 1'b1; d_slave = data_fn(a + 32'(j * (DW / 8)));
            flush_slave = (flush_at == j + 1);
            @(negedge s_clk);
            v_slave = 1'b0; flush_slave = 1'b0;
            if (!s_rst_n) ab = 1'b1;
            else check("burst_hold", {rd_burst_req, rd_burst_addr, rd_burst_len}, {1'b1, a, l});
          end
        end
        if (!ab) begin
          rd_burst_finish = 1'b1;
          @(negedge s_clk);
          rd_burst_finish = 1'b0;
          check("req_drop", rd_burst_req, 1'b0);
        end
      end
    end
  end

  // Model: FIFO occupancy and consumer position follow from the beats delivered and accepted.
  always @(posedge s_clk) begin : model
    bit wr, rd;
    if (!chk_en || !s_rst_n) begin
      mcount = 0; out_idx = 0;
    end else begin
      rd = (mcount > 0) && i_weight_ready;
      wr = rd_burst_valid;
      if (rd) out_idx++;
      mcount = mcount + int'(wr) - int'(rd);
    end
  end

  always @(negedge s_clk) begin : compare
    if (s_rst_n && o_done) done_cnt++;
    if (s_rst_n && o_weight_valid && i_weight_ready) acc_cnt++;
    if (chk_en && s_rst_n) begin
      check("valid", o_weight_valid, mcount > 0);
      check("pempty", o_pempty, mcount < PTH);
      if (mcount > 0) check("data", o_weight_data, data_fn(job_base + 32'(out_idx * (DW / 8))));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge s_clk);
  endtask

  task automatic start_job(input logic [AW-1:0] base, input int total);
    @(negedge s_clk);
    i_base_addr = base; i_total_beats = BCW'(total); i_start = 1'b1;
    @(negedge s_clk);
    i_start = 1'b0;
  endtask

  task automatic setup_job(input logic [AW-1:0] base, input int total, input int rmode, input int gmax, input bit en);
    @(negedge s_clk);
    job_base = base; job_total = total; obs_base = n_obs;
    ready_mode = rmode; gap_max = gmax; chk_en = en;
    d0 = done_cnt; a0 = acc_cnt;
  endtask

  task automatic finish_job(input string tag, input int total);
    c = 0;
    while ((done_cnt == d0 || acc_cnt - a0 < total) && c < 20000) begin
      @(negedge s_clk); c++;
    end
    check({tag, "_timeout"}, c < 20000, 1'b1);
    tick(2);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_beats"}, acc_cnt - a0, total);
    check({tag, "_bursts"}, n_obs - obs_base, (total + BL - 1) / BL);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_overflow"}, o_overflow, 1'b0);
    chk_en = 1'b0;
  endtask

  initial begin : main
    s_rst_n = 1'b0;
    #23;
    check("rst_valid", o_weight_valid, 1'b0);
    check("rst_pempty", o_pempty, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_req", rd_burst_req, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_overflow", o_overflow, 1'b0);
    @(negedge s_clk);
    s_rst_n = 1'b1;
    tick(2);

    // Two full bursts; a second start mid-run must be ignored.
    setup_job(32'h1000, 64, 1, 0, 1'b1);
    start_job(32'h1000, 64);
    c = 0;
    while (!rd_burst_req && c < 50) begin @(negedge s_clk); c++; end
    check("t1_req_seen", rd_burst_req, 1'b1);
    i_base_addr = 32'h9000; i_total_beats = BCW'(5); i_start = 1'b1;
    @(negedge s_clk);
    i_start = 1'b0;
    finish_job("t1", 64);
    check("t1_addr0", obs_addr[obs_base], 32'h1000);
    check("t1_addr1", obs_addr[obs_base + 1], 32'h1100);
    check("t1_len0", obs_len[obs_base], 32);
    check("t1_len1", obs_len[obs_base + 1], 32);

    // Short tail burst.
    setup_job(32'h1000, 40, 2, 1, 1'b1);
    start_job(32'h1000, 40);
    finish_job("t2", 40);
    check("t2_len0", obs_len[obs_base], 32);
    check("t2_addr1", obs_addr[obs_base + 1], 32'h1100);
    check("t2_len1", obs_len[obs_base + 1], 8);

    // Zero-length job finishes immediately.
    setup_job(32'h5000, 0, 1, 0, 1'b1);
    start_job(32'h5000, 0);
    tick(3);
    check("t3_done", done_cnt - d0, 1);
    check("t3_busy", o_busy, 1'b0);
    check("t3_bursts", n_obs - obs_base, 0);
    chk_en = 1'b0;

    // Back-pressure: issue stalls at 16 bursts with the FIFO full, then resumes.
    setup_job(32'h4000, 1024, 0, 0, 1'b1);
    start_job(32'h4000, 1024);
    c = 0;
    while (mcount < DEPTH && c < 3000) begin @(negedge s_clk); c++; end
    check("bp_fill_timeout", c < 3000, 1'b1);
    tick(100);
    check("bp_bursts_stalled", n_obs - obs_base, 16);
    check("bp_req_idle", rd_burst_req, 1'b0);
    check("bp_overflow", o_overflow, 1'b0);
    check("bp_busy", o_busy, 1'b1);
    check("bp_pempty", o_pempty, 1'b0);
    ready_mode = 2;
    finish_job("bp", 1024);

    // Random jobs.
    for (int t = 0; t < 6; t++) begin
      logic [AW-1:0] rb;
      int rt;
      rb = 32'($urandom_range(0, 32'h00FF_FFFF)) & 32'hFFFF_FFF8;
      rt = $urandom_range(1, 300);
      setup_job(rb, rt, 2 - (t % 2), t % 3, 1'b1);
      start_job(rb, rt);
      finish_job("rnd", rt);
    end

    // Flush on the 5th beat of the first burst.
    setup_job(32'h2000, 64, 0, 0, 1'b0);
    flush_at = 5;
    start_job(32'h2000, 64);
    c = 0;
    while (o_busy && c < 500) begin @(negedge s_clk); c++; end
    check("fl_timeout", c < 500, 1'b1);
    check("fl_valid", o_weight_valid, 1'b0);
    check("fl_req", rd_burst_req, 1'b0);
    tick(40);
    check("fl_no_done", done_cnt - d0, 0);
    check("fl_bursts", n_obs - obs_base, 1);
    check("fl_busy", o_busy, 1'b0);
    flush_at = 0;

    // Fill the FIFO directly, then overrun it by one beat.
    setup_job(32'h0, 0, 0, 0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      v_main = 1'b1; d_main = 64'(i) + 64'h100;
      @(negedge s_clk);
      if (i == PTH - 2) check("ov_pempty_63", o_pempty, 1'b1);
      if (i == PTH - 1) check("ov_pempty_64", o_pempty, 1'b0);
      if (i == DEPTH - 1) check("ov_not_yet", o_overflow, 1'b0);
    end
    v_main = 1'b0;
    check("ov_set", o_overflow, 1'b1);
    check("ov_head", o_weight_data, 64'h100);
    tick(3);
    check("ov_sticky", o_overflow, 1'b1);
    flush_main = 1'b1;
    @(negedge s_clk);
    flush_main = 1'b0;
    check("ov_flush_valid", o_weight_valid, 1'b0);
    check("ov_flush_pempty", o_pempty, 1'b1);
    check("ov_flush_sticky", o_overflow, 1'b1);

    // Reset in the middle of a burst.
    setup_job(32'h3000, 64, 0, 0, 1'b0);
    start_job(32'h3000, 64);
    c = 0;
    while (!rd_burst_req && c < 50) begin @(negedge s_clk); c++; end
    check("rs_req_seen", rd_burst_req, 1'b1);
    tick(4);
    #2 s_rst_n = 1'b0;
    #1;
    check("rs_req", rd_burst_req, 1'b0);
    check("rs_valid", o_weight_valid, 1'b0);
    check("rs_pempty", o_pempty, 1'b1);
    check("rs_busy", o_busy, 1'b0);
    check("rs_overflow", o_overflow, 1'b0);
    tick(3);
    s_rst_n = 1'b1;
    tick(3);
    check("rs_idle_busy", o_busy, 1'b0);
    check("rs_idle_req", rd_burst_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
